regfile_write_monitor: RTL
==========================

Name: regfile_write_monitor

Overview:
- Bench-side monitor directly upstream of the register-file scoreboard.
- Samples the single-cycle core's register-file write port every clock and maintains a shadow copy of all 32 architectural registers, exported as a packed 32x32 array for the scoreboard.
- Buffers each nonzero-destination write as a sequenced event in a FIFO, drained by the scoreboard over a valid/ready handshake.
- Counts x0-write attempts and FIFO drops so the scoreboard can flag lost visibility.

Parameters:
- DEPTH, 8, event FIFO depth; power of 2, minimum 2.
- SEQ_W, 16, width of the event sequence number; wraps modulo 2^SEQ_W.
- CNT_W, 8, width of the saturating x0-write and drop counters.

Ports:
- i_clk  input  1  clock; all state samples on the rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_rd_wren  input  1  register-file write enable from the core.
- i_rd_addr  input  5  destination register index.
- i_rd_data  input  32  write data.
- o_shadow_regs  output  [31:0][31:0]  shadow register array; entry 0 always zero.
- o_evt_valid  output  1  FIFO head holds a valid event.
- i_evt_ready  input  1  consumer accepts the head event this cycle.
- o_evt_addr  output  5  head event register index.
- o_evt_data  output  32  head event data.
- o_evt_seq  output  SEQ_W  head event sequence number.
- o_level  output  $clog2(DEPTH)+1  current FIFO occupancy.
- o_overflow  output  1  sticky: at least one event has been dropped.
- o_drop_cnt  output  CNT_W  saturating count of dropped events.
- o_x0_wr_cnt  output  CNT_W  saturating count of writes targeting x0.

Behaviour:
- Reset (asynchronous, any time, including mid-drain):
  - Shadow array, FIFO pointers, o_level, seq counter, o_overflow, o_drop_cnt and o_x0_wr_cnt clear to 0.
  - o_evt_valid = 0; o_evt_addr, o_evt_data and o_evt_seq = 0.
  - Events in flight are discarded.
- Write qualification: a write is observed when i_rd_wren = 1 on a rising edge.
- i_rd_addr == 0:
  - No shadow update and no FIFO push.
  - o_x0_wr_cnt increments, saturating at 2^CNT_W-1.
  - Seq counter is not advanced.
- i_rd_addr != 0:
  - Shadow entry updated at the edge and visible on o_shadow_regs the following cycle (1-cycle latency).
  - An event {addr, data, seq} is offered to the FIFO.
  - Seq counter advances by 1 whether or not the push succeeds, so a drop shows as a gap in o_evt_seq.
- First observed event carries seq 0.
- FIFO:
  - Pop occurs when o_evt_valid && i_evt_ready.
  - First-word-fall-through: a push into an empty FIFO drives o_evt_valid and the head fields from the next cycle (1-cycle latency). No same-cycle bypass.
  - Head fields are stable while o_evt_valid = 1 and i_evt_ready = 0.
  - i_evt_ready with o_evt_valid = 0 has no effect.
- Full, push and pop in the same cycle: both are performed; level stays DEPTH; no drop.
- Full, push without pop:
  - Event dropped.
  - o_overflow set and held until reset.
  - o_drop_cnt increments, saturating.
  - Shadow array is still updated.
- Empty, push and pop in the same cycle: not possible because o_evt_valid = 0; the push is accepted.
- o_level: +1 on push only, -1 on pop only, unchanged on both; range 0..DEPTH.
- Pointer wrap: read and write pointers wrap modulo DEPTH. Full and empty are distinguished by level (or an extra pointer bit); never by pointer equality alone.
- Seq wrap: 2^SEQ_W-1 is followed by 0.
- Back-to-back writes to the same register: each produces its own event. The shadow holds the last value.
- o_shadow_regs[0] is constant zero, a combinational tie-off with no storage.
- All other outputs are registered.

Test Plan:
- Reset release, then writes x5=0xDEADBEEF and x6=0x12345678 on consecutive cycles with i_evt_ready=1:
  - o_shadow_regs[5] and [6] update one cycle after each write.
  - Events are seen with seq 0 then 1, addr 5 then 6.
  - o_level returns to 0.
- Write x0=0xFFFFFFFF three times:
  - o_shadow_regs[0] stays 0.
  - o_x0_wr_cnt = 3.
  - No event; the seq counter is unaffected, so the next x1 write carries seq 0.
- i_evt_ready=0, DEPTH+2 = 10 writes to x1..x10:
  - o_level = 8.
  - o_overflow = 1, o_drop_cnt = 2.
  - Draining yields seq 0..7 in order; o_shadow_regs[9]/[10] still hold the written values.
- FIFO full; one cycle with push (x3=0xA5A5A5A5) and i_evt_ready=1:
  - Head pops.
  - Level stays 8, o_drop_cnt unchanged.
  - The new event is the last one drained.
- Hold i_evt_ready=0 with one event queued for 5 cycles:
  - o_evt_valid, addr, data and seq are stable throughout.
  - Assert ready: the pop happens, and o_evt_valid drops the next cycle.
- Assert i_rst_n=0 asynchronously mid-cycle with 4 events queued and nonzero shadow:
  - All outputs go to 0 immediately, without waiting for a clock edge.
  - After release, the next x2 write produces seq 0.

Source files
------------

// File: rtl/regfile_write_monitor.sv
// Register-file write monitor.
// Every clock it samples the core's register-file write port. It keeps a shadow
// copy of the 32 architectural registers. Each write to a nonzero register
// becomes a sequenced event in a first-word-fall-through FIFO, which the
// scoreboard drains with a valid/ready handshake. Writes to x0 and dropped
// events are counted in saturating counters.
module regfile_write_monitor #(
    parameter int DEPTH = 8,
    parameter int SEQ_W = 16,
    parameter int CNT_W = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_rd_wren,
    input  logic [4:0]                 i_rd_addr,
    input  logic [31:0]                i_rd_data,
    output logic [31:0][31:0]          o_shadow_regs,
    output logic                       o_evt_valid,
    input  logic                       i_evt_ready,
    output logic [4:0]                 o_evt_addr,
    output logic [31:0]                o_evt_data,
    output logic [SEQ_W-1:0]           o_evt_seq,
    output logic [$clog2(DEPTH):0]     o_level,
    output logic                       o_overflow,
    output logic [CNT_W-1:0]           o_drop_cnt,
    output logic [CNT_W-1:0]           o_x0_wr_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int ENT_W = 5 + 32 + SEQ_W;

    // Saturating increment shared by the x0-write and drop counters.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        if (cnt == {CNT_W{1'b1}}) begin
            return cnt;
        end
        return cnt + CNT_W'(1);
    endfunction

    // Shadow storage for x1..x31; x0 has no storage.
    logic [31:0]      shadow_q [1:31];

    // Event FIFO storage and control.
    logic [ENT_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] rd_ptr_nxt;
    logic [LVL_W-1:0] level_q;
    logic [LVL_W-1:0] level_nxt;
    logic [LVL_W-1:0] level_after_pop;
    logic [SEQ_W-1:0] seq_q;

    // Registered head of the FIFO.
    logic             head_valid_q;
    logic [ENT_W-1:0] head_q;
    logic [ENT_W-1:0] head_nxt;
    logic             head_valid_nxt;

    logic             overflow_q;
    logic [CNT_W-1:0] drop_cnt_q;
    logic [CNT_W-1:0] x0_cnt_q;

    // Handshake and write qualification.
    logic             obs_x0;
    logic             obs_evt;
    logic             full;
    logic             pop;
    logic             push;
    logic             drop;
    logic [ENT_W-1:0] push_ent;

    assign obs_x0   = i_rd_wren && (i_rd_addr == 5'd0);
    assign obs_evt  = i_rd_wren && (i_rd_addr != 5'd0);
    assign full     = (level_q == LVL_W'(DEPTH));
    assign pop      = head_valid_q && i_evt_ready;
    // A full FIFO can still accept a push when the head leaves in the same cycle.
    assign push     = obs_evt && (!full || pop);
    assign drop     = obs_evt && full && !pop;
    assign push_ent = {i_rd_addr, i_rd_data, seq_q};

    // Next pointer, occupancy and head selection, with bypass when the FIFO is empty.
    always_comb begin
        rd_ptr_nxt      = rd_ptr_q;
        level_nxt       = level_q;
        level_after_pop = level_q;
        if (pop) begin
            rd_ptr_nxt      = rd_ptr_q + PTR_W'(1);
            level_after_pop = level_q - LVL_W'(1);
        end
        if (push && !pop) begin
            level_nxt = level_q + LVL_W'(1);
        end else if (pop && !push) begin
            level_nxt = level_q - LVL_W'(1);
        end
        head_valid_nxt = (level_nxt != '0);
        // The new head is the incoming event when nothing older remains queued.
        if (push && (level_after_pop == '0)) begin
            head_nxt = push_ent;
        end else begin
            head_nxt = mem_q[rd_ptr_nxt];
        end
    end

    // Shadow register file update on every nonzero-destination write.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 1; i < 32; i++) begin
                shadow_q[i] <= '0;
            end
        end else if (obs_evt) begin
            shadow_q[i_rd_addr] <= i_rd_data;
        end
    end

    // FIFO payload storage; only the occupied slots are ever read.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_ent;
        end
    end

    // FIFO pointers, occupancy and sequence number.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            seq_q    <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            rd_ptr_q <= rd_ptr_nxt;
            level_q  <= level_nxt;
            // A dropped event still consumes a sequence number, which leaves a visible gap.
            if (obs_evt) begin
                seq_q <= seq_q + SEQ_W'(1);
            end
        end
    end

    // Registered head fields; they hold while the consumer stalls.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            head_valid_q <= 1'b0;
            head_q       <= '0;
        end else begin
            head_valid_q <= head_valid_nxt;
            if (head_valid_nxt) begin
                head_q <= head_nxt;
            end
        end
    end

    // Visibility-loss bookkeeping: sticky overflow and saturating counters.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
            x0_cnt_q   <= '0;
        end else begin
            if (drop) begin
                overflow_q <= 1'b1;
                drop_cnt_q <= sat_inc(drop_cnt_q);
            end
            if (obs_x0) begin
                x0_cnt_q <= sat_inc(x0_cnt_q);
            end
        end
    end

    // Export the shadow array with entry 0 tied to zero.
    always_comb begin
        o_shadow_regs[0] = '0;
        for (int i = 1; i < 32; i++) begin
            o_shadow_regs[i] = shadow_q[i];
        end
    end

    assign o_evt_valid = head_valid_q;
    assign o_evt_addr  = head_q[ENT_W-1 -: 5];
    assign o_evt_data  = head_q[SEQ_W +: 32];
    assign o_evt_seq   = head_q[SEQ_W-1:0];
    assign o_level     = level_q;
    assign o_overflow  = overflow_q;
    assign o_drop_cnt  = drop_cnt_q;
    assign o_x0_wr_cnt = x0_cnt_q;

endmodule
